// File: rtl/fft_peak_finder.sv
// Squared-magnitude pipeline over a streamed FFT frame: writes a saturated 8-bit
// spectrum to the display RAM and reports the peak bin of the lower half.
module fft_peak_finder #(
  parameter int FFT_LEN     = 256,
  parameter int DATA_W      = 16,
  parameter int SCALE_SHIFT = 22
) (
  input  logic                       ad_clk,
  input  logic                       sys_rst_n,
  input  logic [2*DATA_W-1:0]        m_axis_data_tdata,
  input  logic                       m_axis_data_tvalid,
  input  logic                       m_axis_data_tlast,
  output logic                       m_axis_data_tready,
  output logic                       fft_ram_wr_en,
  output logic [$clog2(FFT_LEN)-1:0] fft_ram_waddr,
  output logic [7:0]                 fft_ram_wdata,
  output logic [$clog2(FFT_LEN)-1:0] ram_waddr_max,
  output logic                       fft_done,
  output logic                       frame_err
);
  localparam int AW = $clog2(FFT_LEN);
  localparam int MW = 2 * DATA_W;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECV   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;
  localparam logic [AW-1:0] LAST_BIN = AW'(FFT_LEN - 1);
  localparam logic [AW-1:0] HALF_BIN = AW'(FFT_LEN / 2);

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        bin_q, bin_d;
  logic [1:0]           fin_cnt_q, fin_cnt_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        max_q, max_d;
  logic                 s1_vld_q, s1_vld_d, s1_pk_q, s1_pk_d;
  logic [AW-1:0]        s1_bin_q, s1_bin_d;
  logic signed [DATA_W-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic                 s2_vld_q, s2_vld_d, s2_pk_q, s2_pk_d;
  logic [AW-1:0]        s2_bin_q, s2_bin_d;
  logic [MW-1:0]        s2_re_sq_q, s2_re_sq_d, s2_im_sq_q, s2_im_sq_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        waddr_q, waddr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [AW-1:0]        pk_idx_q, pk_idx_d;
  logic [MW-1:0]        pk_mag_q, pk_mag_d;

  logic                 hs, is_last, early, pk_rst;
  logic signed [MW-1:0] re_x, im_x;
  logic [MW-1:0]        mag, scaled;

  // A beat transfers on any cycle where tvalid && tready; tready is low only while draining.
  assign m_axis_data_tready = (state_q != ST_FINISH);
  assign hs      = m_axis_data_tvalid && m_axis_data_tready;
  assign is_last = (bin_q == LAST_BIN);
  assign early   = hs && m_axis_data_tlast && !is_last;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    fin_cnt_d = fin_cnt_q;
    done_d    = 1'b0;
    max_d     = max_q;
    pk_rst    = 1'b0;
    err_d     = hs && (m_axis_data_tlast != is_last);
    case (state_q)
      ST_IDLE, ST_RECV: begin
        if (hs) begin
          pk_rst = (state_q == ST_IDLE);
          if (early) begin
            state_d = ST_IDLE;
            bin_d   = '0;
          end else if (is_last) begin
            state_d   = ST_FINISH;
            bin_d     = '0;
            fin_cnt_d = 2'd0;
          end else begin
            state_d = ST_RECV;
            bin_d   = bin_q + AW'(1);
          end
        end
      end
      ST_FINISH: begin
        fin_cnt_d = fin_cnt_q + 2'd1;
        if (fin_cnt_q == 2'd2) begin
          state_d   = ST_IDLE;
          fin_cnt_d = 2'd0;
          done_d    = 1'b1;
          max_d     = pk_idx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Abort clears the peak-candidate flags of in-flight beats so a stale frame
  // cannot disturb the next frame's search; its RAM writes still complete.
  always_comb begin
    s1_vld_d   = hs;
    s1_pk_d    = hs && !early && (bin_q != '0) && (bin_q < HALF_BIN);
    s1_bin_d   = bin_q;
    s1_re_d    = m_axis_data_tdata[DATA_W-1:0];
    s1_im_d    = m_axis_data_tdata[MW-1:DATA_W];
    re_x       = MW'(s1_re_q);
    im_x       = MW'(s1_im_q);
    s2_vld_d   = s1_vld_q;
    s2_pk_d    = s1_pk_q && !early;
    s2_bin_d   = s1_bin_q;
    s2_re_sq_d = re_x * re_x;
    s2_im_sq_d = im_x * im_x;
    mag        = s2_re_sq_q + s2_im_sq_q;
    scaled     = mag >> SCALE_SHIFT;
    wr_en_d    = s2_vld_q;
    waddr_d    = s2_bin_q;
    wdata_d    = (scaled > MW'(255)) ? 8'hff : scaled[7:0];
    pk_idx_d   = pk_idx_q;
    pk_mag_d   = pk_mag_q;
    if (pk_rst) begin
      pk_idx_d = AW'(1);
      pk_mag_d = '0;
    end else if (s2_vld_q && s2_pk_q && (mag > pk_mag_q)) begin
      pk_idx_d = s2_bin_q;
      pk_mag_d = mag;
    end
  end

  always_ff @(posedge ad_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      fin_cnt_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      max_q      <= AW'(1);
      s1_vld_q   <= 1'b0;
      s1_pk_q    <= 1'b0;
      s1_bin_q   <= '0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_pk_q    <= 1'b0;
      s2_bin_q   <= '0;
      s2_re_sq_q <= '0;
      s2_im_sq_q <= '0;
      wr_en_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pk_idx_q   <= AW'(1);
      pk_mag_q   <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      fin_cnt_q  <= fin_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      max_q      <= max_d;
      s1_vld_q   <= s1_vld_d;
      s1_pk_q    <= s1_pk_d;
      s1_bin_q   <= s1_bin_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      s2_vld_q   <= s2_vld_d;
      s2_pk_q    <= s2_pk_d;
      s2_bin_q   <= s2_bin_d;
      s2_re_sq_q <= s2_re_sq_d;
      s2_im_sq_q <= s2_im_sq_d;
      wr_en_q    <= wr_en_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      pk_idx_q   <= pk_idx_d;
      pk_mag_q   <= pk_mag_d;
    end
  end

  assign fft_ram_wr_en = wr_en_q;
  assign fft_ram_waddr = waddr_q;
  assign fft_ram_wdata = wdata_q;
  assign ram_waddr_max = max_q;
  assign fft_done      = done_q;
  assign frame_err     = err_q;
endmodule

// File: tb/tb_fft_peak_finder.sv
// Frame-level bench for fft_peak_finder: table of frames with expected peak and
// pulses, plus a RAM-write scoreboard checking address, data and latency.
module tb_fft_peak_finder;
  logic        ad_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tlast;
  logic        m_axis_data_tready;
  logic        fft_ram_wr_en;
  logic [7:0]  fft_ram_waddr;
  logic [7:0]  fft_ram_wdata;
  logic [7:0]  ram_waddr_max;
  logic        fft_done;
  logic        frame_err;

  fft_peak_finder dut (
    .ad_clk             (ad_clk),
    .sys_rst_n          (sys_rst_n),
    .m_axis_data_tdata  (m_axis_data_tdata),
    .m_axis_data_tvalid (m_axis_data_tvalid),
    .m_axis_data_tlast  (m_axis_data_tlast),
    .m_axis_data_tready (m_axis_data_tready),
    .fft_ram_wr_en      (fft_ram_wr_en),
    .fft_ram_waddr      (fft_ram_waddr),
    .fft_ram_wdata      (fft_ram_wdata),
    .ram_waddr_max      (ram_waddr_max),
    .fft_done           (fft_done),
    .frame_err          (frame_err)
  );

  // clock / reset
  always #5 ad_clk = ~ad_clk;
  int cyc = 0;
  always @(posedge ad_clk) cyc <= cyc + 1;

  typedef struct {
    int nb; int tlast_bin; bit gap;
    int b0; int r0; int i0;
    int b1; int r1; int i1;
    int b2; int r2; int i2;
    int exp_max; bit exp_done; bit exp_err;
  } vec_t;

  vec_t        vecs[11];
  int          re_arr[256];
  int          im_arr[256];
  logic [47:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int re, input int im);
    longint m;
    m = longint'(re) * re + longint'(im) * im;
    m = m / 4194304;
    if (m > 255) return 8'd255;
    return m[7:0];
  endfunction

  // driver tasks
  task automatic fill(input vec_t v);
    for (int i = 0; i < 256; i++) begin
      re_arr[i] = 0;
      im_arr[i] = 0;
    end
    if (v.b0 >= 0) begin re_arr[v.b0] = v.r0; im_arr[v.b0] = v.i0; end
    if (v.b1 >= 0) begin re_arr[v.b1] = v.r1; im_arr[v.b1] = v.i1; end
    if (v.b2 >= 0) begin re_arr[v.b2] = v.r2; im_arr[v.b2] = v.i2; end
  endtask

  task automatic drive_beat(input int bin, input bit last);
    int w;
    m_axis_data_tdata  = {16'(im_arr[bin]), 16'(re_arr[bin])};
    m_axis_data_tvalid = 1'b1;
    m_axis_data_tlast  = last;
    w = 0;
    while (!m_axis_data_tready && w < 16) begin
      @(negedge ad_clk);
      w++;
    end
    if (!m_axis_data_tready) begin
      total++;
      bad++;
      $display("FAIL hs_timeout: bin %0d tready stuck at 0", bin);
    end else begin
      exp_q.push_back({8'(bin), exp_pix(re_arr[bin], im_arr[bin]), 32'(cyc + 3)});
    end
    @(negedge ad_clk);
  endtask

  task automatic run_frame(input vec_t v);
    int d0, w0, e0;
    fill(v);
    d0 = done_cnt;
    w0 = wr_cnt;
    e0 = err_cnt;
    for (int i = 0; i < v.nb; i++) begin
      if (v.gap && i > 0) begin
        m_axis_data_tvalid = 1'b0;
        @(negedge ad_clk);
      end
      drive_beat(i, i == v.tlast_bin);
    end
    m_axis_data_tvalid = 1'b0;
    m_axis_data_tlast  = 1'b0;
    chk("frame_err_pulse", frame_err, v.exp_err);
    if (v.exp_done) begin
      chk("tready_drain1", m_axis_data_tready, 0);
      @(negedge ad_clk);
      chk("tready_drain2", m_axis_data_tready, 0);
      chk("frame_err_clear", frame_err, 0);
      chk("fft_done_early", fft_done, 0);
      @(negedge ad_clk);
      chk("tready_drain3", m_axis_data_tready, 0);
      @(negedge ad_clk);
      chk("fft_done_t4", fft_done, 1);
      chk("tready_back", m_axis_data_tready, 1);
      chk("ram_waddr_max", ram_waddr_max, v.exp_max);
      @(negedge ad_clk);
      chk("fft_done_width", fft_done, 0);
    end else begin
      @(negedge ad_clk);
      chk("frame_err_clear", frame_err, 0);
      repeat (4) @(negedge ad_clk);
      chk("ram_waddr_max_hold", ram_waddr_max, v.exp_max);
    end
    chk("write_count", wr_cnt - w0, v.nb);
    chk("done_count", done_cnt - d0, v.exp_done ? 1 : 0);
    chk("err_count", err_cnt - e0, v.exp_err ? 1 : 0);
  endtask

  // scoreboard
  always @(negedge ad_clk) begin
    if (sys_rst_n) begin
      if (fft_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (fft_ram_wr_en) begin
        logic [47:0] e;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ram_write_unexpected: addr %0d data %0d", fft_ram_waddr, fft_ram_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("ram_waddr", fft_ram_waddr, e[47:40]);
          chk("ram_wdata", fft_ram_wdata, e[39:32]);
          chk("ram_write_cycle", cyc, e[31:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    //        nb  tl   gap b0  r0      i0      b1   r1   i1   b2   r2      i2      max done err
    vecs[0] = '{256, 255, 0, 50, 1000,  0,      -1,  0,   0,   -1,  0,      0,      50, 1, 0};
    vecs[1] = '{256, 255, 0, 50, 300,   400,    206, 400, 300, 0,   -32768, -32768, 50, 1, 0};
    vecs[2] = '{256, 255, 0, 30, 500,   500,    60,  500, 500, -1,  0,      0,      30, 1, 0};
    vecs[3] = '{256, 255, 0, 60, -32768, 0,     -1,  0,   0,   -1,  0,      0,      60, 1, 0};
    vecs[4] = '{256, 255, 0, 50, 1000,  0,      -1,  0,   0,   -1,  0,      0,      50, 1, 0};
    vecs[5] = '{101, 100, 0, 70, 2000,  0,      -1,  0,   0,   -1,  0,      0,      50, 0, 1};
    vecs[6] = '{256, 255, 0, 10, 700,   -700,   -1,  0,   0,   -1,  0,      0,      10, 1, 0};
    vecs[7] = '{256, 255, 1, 90, -1500, 200,    -1,  0,   0,   -1,  0,      0,      90, 1, 0};
    vecs[8] = '{256, 255, 0, 128, 5000, 0,      0,   9000, 9000, 255, 3000, 0,      1,  1, 0};
    vecs[9] = '{256, -1,  0, 127, 100,  100,    128, 5000, 5000, -1, 0,     0,      127, 1, 1};
    vecs[10] = '{256, 255, 0, 40, 20000, 20000, -1,  0,   0,   -1,  0,      0,      40, 1, 0};

    sys_rst_n          = 1'b0;
    m_axis_data_tdata  = '0;
    m_axis_data_tvalid = 1'b0;
    m_axis_data_tlast  = 1'b0;
    repeat (3) @(negedge ad_clk);
    #2 sys_rst_n = 1'b1;
    @(negedge ad_clk);
    chk("reset_tready", m_axis_data_tready, 1);
    chk("reset_waddr_max", ram_waddr_max, 1);
    chk("reset_wr_en", fft_ram_wr_en, 0);
    chk("reset_waddr", fft_ram_waddr, 0);
    chk("reset_wdata", fft_ram_wdata, 0);
    chk("reset_done", fft_done, 0);
    chk("reset_err", frame_err, 0);

    for (int k = 0; k < 10; k++) begin
      run_frame(vecs[k]);
      repeat ($urandom_range(0, 3)) @(negedge ad_clk);
    end

    // reset in the middle of a frame, then a clean frame
    fill(vecs[10]);
    d0 = done_cnt;
    for (int i = 0; i <= 120; i++) drive_beat(i, 1'b0);
    m_axis_data_tvalid = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_tready", m_axis_data_tready, 1);
    chk("midrst_waddr_max", ram_waddr_max, 1);
    chk("midrst_wr_en", fft_ram_wr_en, 0);
    chk("midrst_done", fft_done, 0);
    chk("midrst_err", frame_err, 0);
    exp_q.delete();
    @(negedge ad_clk);
    #2 sys_rst_n = 1'b1;
    repeat (5) @(negedge ad_clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_no_writes", fft_ram_wr_en, 0);
    run_frame(vecs[10]);

    repeat (5) @(negedge ad_clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
